// File: rtl/imem_port_arbiter.sv
// Shares the dual-word imem read port between the 2-wide fetch unit and a debug/loader requester.
// Optional IMEM_ARB_PERF_EN adds grant and killed-response counters (perf_fetch_gnt, perf_dbg_gnt, perf_killed).
module imem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_gnt,
    output logic            fetch_rvalid,
    output logic [XLEN-1:0] fetch_rpc0,
    output logic [XLEN-1:0] fetch_rpc1,
    output logic [XLEN-1:0] fetch_rdata0,
    output logic [XLEN-1:0] fetch_rdata1,
    input  logic            dbg_req,
    input  logic [XLEN-1:0] dbg_addr,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_addr0,
    output logic [XLEN-1:0] imem_addr1,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_pc0,
    input  logic [XLEN-1:0] imem_pc1,
    input  logic [XLEN-1:0] imem_rdata0,
    input  logic [XLEN-1:0] imem_rdata1,
    output logic            err_spurious
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_fetch_gnt,
    output logic [31:0]     perf_dbg_gnt,
    output logic [31:0]     perf_killed
`endif
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTST);
    localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);
    localparam logic [XLEN-1:0]  WORD_STEP = XLEN'(4);

    // Owner bit: 1 = debug, 0 = fetch.
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [MAX_OUTST-1:0] kill_q, kill_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [STV_W-1:0]     starve_q, starve_d;

    logic            imem_ren_q, imem_ren_d;
    logic [XLEN-1:0] imem_addr0_q, imem_addr0_d;
    logic [XLEN-1:0] imem_addr1_q, imem_addr1_d;
    logic            fetch_rvalid_q, fetch_rvalid_d;
    logic [XLEN-1:0] fetch_rpc0_q, fetch_rpc0_d;
    logic [XLEN-1:0] fetch_rpc1_q, fetch_rpc1_d;
    logic [XLEN-1:0] fetch_rdata0_q, fetch_rdata0_d;
    logic [XLEN-1:0] fetch_rdata1_q, fetch_rdata1_d;
    logic            dbg_rvalid_q, dbg_rvalid_d;
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
    logic            err_spurious_q, err_spurious_d;

    logic            fifo_empty;
    logic            pop;
    logic            head_is_dbg;
    logic            head_kill;
    logic            slot_free;
    logic            fetch_live;
    logic            dbg_prio;
    logic            fetch_win;
    logic            dbg_win;
    logic            push;
    logic [XLEN-1:0] issue_addr;

    always_comb begin
        fifo_empty  = (count_q == '0);
        pop         = imem_valid && !fifo_empty;
        head_is_dbg = owner_q[rd_ptr_q];
        // A flush in the same cycle as the pop still kills the popping fetch entry.
        head_kill   = kill_q[rd_ptr_q] | (flush & ~head_is_dbg);
        // Grants are forced low while reset is asserted so every output reads 0 in reset.
        slot_free   = reset_n && ((count_q != CNT_FULL) || pop);
        fetch_live  = fetch_req && !flush;
        dbg_prio    = dbg_req && (starve_q >= STV_MAX);
        dbg_win     = slot_free && dbg_req && (dbg_prio || !fetch_live);
        fetch_win   = slot_free && fetch_live && !dbg_prio;
        push        = fetch_win || dbg_win;
        issue_addr  = dbg_win ? dbg_addr : fetch_addr;
    end

    assign fetch_gnt = fetch_win;
    assign dbg_gnt   = dbg_win;

    always_comb begin
        owner_d = owner_q;
        kill_d  = kill_q;
        if (flush) begin
            kill_d = kill_q | ~owner_q;
        end
        if (push) begin
            owner_d[wr_ptr_q] = dbg_win;
            kill_d[wr_ptr_q]  = 1'b0;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (dbg_req && !dbg_win) begin
            starve_d = (starve_q >= STV_MAX) ? STV_MAX : starve_q + STV_W'(1);
        end else begin
            starve_d = '0;
        end

        imem_ren_d   = push;
        imem_addr0_d = imem_addr0_q;
        imem_addr1_d = imem_addr1_q;
        if (push) begin
            imem_addr0_d = issue_addr;
            imem_addr1_d = issue_addr + WORD_STEP;
        end

        fetch_rvalid_d = pop && !head_is_dbg && !head_kill;
        fetch_rpc0_d   = fetch_rpc0_q;
        fetch_rpc1_d   = fetch_rpc1_q;
        fetch_rdata0_d = fetch_rdata0_q;
        fetch_rdata1_d = fetch_rdata1_q;
        if (fetch_rvalid_d) begin
            fetch_rpc0_d   = imem_pc0;
            fetch_rpc1_d   = imem_pc1;
            fetch_rdata0_d = imem_rdata0;
            fetch_rdata1_d = imem_rdata1;
        end

        dbg_rvalid_d = pop && head_is_dbg;
        dbg_rdata_d  = dbg_rvalid_d ? imem_rdata0 : dbg_rdata_q;

        err_spurious_d = err_spurious_q | (imem_valid && fifo_empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q        <= '0;
            kill_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            imem_ren_q     <= 1'b0;
            imem_addr0_q   <= '0;
            imem_addr1_q   <= '0;
            fetch_rvalid_q <= 1'b0;
            fetch_rpc0_q   <= '0;
            fetch_rpc1_q   <= '0;
            fetch_rdata0_q <= '0;
            fetch_rdata1_q <= '0;
            dbg_rvalid_q   <= 1'b0;
            dbg_rdata_q    <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            kill_q         <= kill_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            imem_ren_q     <= imem_ren_d;
            imem_addr0_q   <= imem_addr0_d;
            imem_addr1_q   <= imem_addr1_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_rpc0_q   <= fetch_rpc0_d;
            fetch_rpc1_q   <= fetch_rpc1_d;
            fetch_rdata0_q <= fetch_rdata0_d;
            fetch_rdata1_q <= fetch_rdata1_d;
            dbg_rvalid_q   <= dbg_rvalid_d;
            dbg_rdata_q    <= dbg_rdata_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign imem_ren     = imem_ren_q;
    assign imem_addr0   = imem_addr0_q;
    assign imem_addr1   = imem_addr1_q;
    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_rpc0   = fetch_rpc0_q;
    assign fetch_rpc1   = fetch_rpc1_q;
    assign fetch_rdata0 = fetch_rdata0_q;
    assign fetch_rdata1 = fetch_rdata1_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign err_spurious = err_spurious_q;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fetch_gnt_q, perf_fetch_gnt_d;
    logic [31:0] perf_dbg_gnt_q, perf_dbg_gnt_d;
    logic [31:0] perf_killed_q, perf_killed_d;

    always_comb begin
        perf_fetch_gnt_d = perf_fetch_gnt_q + 32'(fetch_win);
        perf_dbg_gnt_d   = perf_dbg_gnt_q + 32'(dbg_win);
        perf_killed_d    = perf_killed_q + 32'(pop && !head_is_dbg && head_kill);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_gnt_q <= '0;
            perf_dbg_gnt_q   <= '0;
            perf_killed_q    <= '0;
        end else begin
            perf_fetch_gnt_q <= perf_fetch_gnt_d;
            perf_dbg_gnt_q   <= perf_dbg_gnt_d;
            perf_killed_q    <= perf_killed_d;
        end
    end

    assign perf_fetch_gnt = perf_fetch_gnt_q;
    assign perf_dbg_gnt   = perf_dbg_gnt_q;
    assign perf_killed    = perf_killed_q;
`endif

endmodule
